avalon_st_adapter_256_to_128: RTL and testbench
===============================================

Name: avalon_st_adapter_256_to_128

Overview:
- Avalon-ST width downsizer: takes one wide input word and emits it as RATIO narrow output beats, most-significant slice first.
- Performs the inverse of the 128->256 upsizer, so a word upsized then downsized reproduces the original 128-bit beat order.
- Sits on the accelerator's result/readback path, between the 256-bit compute/memory side and 128-bit consumers.
- Sustains one output beat per clock with no bubble between input words.

Parameters:
- OUT_W, 128, output data width in bits.
- RATIO, 2, output beats per input word; input width is OUT_W*RATIO; legal range 2..8.

Ports:
- clock  input  1  single clock; all logic is rising-edge triggered.
- reset  input  1  asynchronous, active-high reset.
- st_in_data  input  OUT_W*RATIO  wide input word.
- st_in_valid  input  1  input word valid.
- st_in_ready  output  1  block can accept st_in_data this cycle.
- st_out_data  output  OUT_W  current narrow slice.
- st_out_valid  output  1  st_out_data is valid.
- st_out_ready  input  1  downstream accepts the slice this cycle.

Behaviour:
- State:
  - hold: register of OUT_W*RATIO bits.
  - beat: counter of clog2(RATIO) bits.
  - full: flag, set while hold contains unsent slices.
- Reset values: hold=0, beat=0, full=0. Therefore st_out_valid=0, st_out_data=0 and st_in_ready=1 immediately after reset.
- Outputs:
  - st_out_valid = full.
  - st_out_data = hold[(RATIO-1-beat)*OUT_W +: OUT_W]. This is combinational from registers, with no path from st_in_*.
- Transfers:
  - out_fire = full && st_out_ready.
  - last = (beat == RATIO-1).
  - st_in_ready = !full || (st_out_ready && last). This has a combinational path from st_out_ready, which is allowed.
  - in_fire = st_in_valid && st_in_ready.
- Register update each clock:
  - in_fire: hold<=st_in_data, beat<=0, full<=1. This takes priority over the out_fire update when both occur in the same cycle.
  - else if out_fire && last: full<=0, beat<=0.
  - else if out_fire: beat<=beat+1.
- Latency: an input accepted at edge N presents its first slice from cycle N+1. Input and the last output slice may fire in the same cycle, giving continuous output with no gap.
- Throughput: one input word accepted every RATIO cycles at full backpressure-free rate.
- Stability: while st_out_valid && !st_out_ready, st_out_data, beat and hold remain unchanged.
- st_out_valid never depends on st_out_ready.
- st_in_valid while not ready: the input is ignored and the word must be held by upstream (Avalon-ST ready latency 0).
- beat never exceeds RATIO-1.
- Reset mid-word: unsent slices are discarded, with no partial-word recovery.

Optional Feature:
- Macro AVST_ADAPTER_PKT_EN.
- When defined, add these ports:
  - st_in_startofpacket  input  1.
  - st_in_endofpacket  input  1.
  - st_out_startofpacket  output  1.
  - st_out_endofpacket  output  1.
- Flag behaviour:
  - sop_hold and eop_hold are captured on in_fire; both reset to 0.
  - st_out_startofpacket = full && sop_hold && (beat==0).
  - st_out_endofpacket = full && eop_hold && last.
- When undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package avst_adapter_pkg holds:
  - default OUT_W and RATIO constants;
  - a function computing the beat counter width (clog2 with a minimum of 1);
  - the slice-select index helper.
- Sub-module: none. The slice mux and counter are small enough to keep inline.

Test Plan:
- Reset release, st_out_ready=1, one word 256'h{AAAA..(128b), 5555..(128b)}: out 128'hAAAA.. at cycle 1, then 128'h5555.. at cycle 2, then st_out_valid=0.
- Streaming: st_in_valid held 1 with words W0..W3 and st_out_ready=1: 8 consecutive out beats with no gap; st_in_ready pulses every second cycle.
- Backpressure: st_out_ready=0 for 5 cycles mid-word: st_out_data and st_out_valid stay stable and st_in_ready=0 throughout. Resume gives the correct second slice.
- Random valid/ready toggling (50%), 1000 words: output equals the concatenated MSB-first slices of the inputs; no loss or duplication.
- Reset asserted after the first slice of a word is sent: st_out_valid drops asynchronously and the remaining slice is never emitted. The next word starts at beat 0.
- With AVST_ADAPTER_PKT_EN, send a 3-word packet (sop on W0, eop on W2): st_out_startofpacket only on beat 0 of W0, st_out_endofpacket only on beat 1 of W2.

Source files
------------

// File: rtl/avst_adapter_pkg.sv
// Shared constants and helpers for the Avalon-ST width adapters.
package avst_adapter_pkg;

    localparam int DEFAULT_OUT_W = 128;
    localparam int DEFAULT_RATIO = 2;

    // Beat counter width; never narrower than one bit.
    function automatic int beat_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Bit offset of the slice sent on a given beat, most-significant slice first.
    function automatic int slice_base(input int beat, input int ratio, input int out_w);
        return (ratio - 1 - beat) * out_w;
    endfunction

endpackage

// File: rtl/avalon_st_adapter_256_to_128.sv
// Avalon-ST downsizer: one OUT_W*RATIO word out as RATIO narrow beats, MSB slice first.
// Packet flags are carried through when AVST_ADAPTER_PKT_EN is defined.
module avalon_st_adapter_256_to_128
    import avst_adapter_pkg::*;
#(
    parameter int OUT_W = DEFAULT_OUT_W,
    parameter int RATIO = DEFAULT_RATIO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OUT_W*RATIO-1:0] st_in_data,
    input  logic                   st_in_valid,
    output logic                   st_in_ready,
    output logic [OUT_W-1:0]       st_out_data,
    output logic                   st_out_valid,
    input  logic                   st_out_ready
`ifdef AVST_ADAPTER_PKT_EN
    ,
    input  logic                   st_in_startofpacket,
    input  logic                   st_in_endofpacket,
    output logic                   st_out_startofpacket,
    output logic                   st_out_endofpacket
`endif
);

    localparam int IN_W = OUT_W * RATIO;
    localparam int BW   = beat_width(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    logic [IN_W-1:0] hold;
    logic [BW-1:0]   beat;
    logic            full;
    logic            last;
    logic            out_fire;
    logic            in_fire;

    assign last         = (beat == LAST_BEAT);
    assign out_fire     = full && st_out_ready;
    // A new word may land in the same cycle the last slice leaves, so output never bubbles.
    assign st_in_ready  = !full || (st_out_ready && last);
    assign in_fire      = st_in_valid && st_in_ready;
    assign st_out_valid = full;

    always_comb begin
        st_out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat == BW'(i)) begin
                st_out_data = hold[slice_base(i, RATIO, OUT_W) +: OUT_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold <= '0;
            beat <= '0;
            full <= 1'b0;
        end else if (in_fire) begin
            hold <= st_in_data;
            beat <= '0;
            full <= 1'b1;
        end else if (out_fire && last) begin
            full <= 1'b0;
            beat <= '0;
        end else if (out_fire) begin
            beat <= beat + BW'(1);
        end
    end

`ifdef AVST_ADAPTER_PKT_EN
    logic sop_hold;
    logic eop_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sop_hold <= 1'b0;
            eop_hold <= 1'b0;
        end else if (in_fire) begin
            sop_hold <= st_in_startofpacket;
            eop_hold <= st_in_endofpacket;
        end
    end

    assign st_out_startofpacket = full && sop_hold && (beat == '0);
    assign st_out_endofpacket   = full && eop_hold && last;
`endif

endmodule

// File: tb/tb_avalon_st_adapter_256_to_128.sv
// Scoreboard bench for avalon_st_adapter_256_to_128 (packet flags checked when AVST_ADAPTER_PKT_EN is defined).
module tb_avalon_st_adapter_256_to_128;

    localparam int OUT_W = 128;
    localparam int RATIO = 2;
    localparam int IN_W  = OUT_W * RATIO;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sop;
        logic             eop;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [IN_W-1:0]  st_in_data = '0;
    logic             st_in_valid = 1'b0;
    logic             st_in_ready;
    logic [OUT_W-1:0] st_out_data;
    logic             st_out_valid;
    logic             st_out_ready = 1'b1;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
`ifdef AVST_ADAPTER_PKT_EN
    logic             st_out_startofpacket;
    logic             st_out_endofpacket;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   run_len = 0;
    int   max_run = 0;

    always #5 clock = ~clock;

    avalon_st_adapter_256_to_128 #(.OUT_W(OUT_W), .RATIO(RATIO)) dut (
        .clock        (clock),
        .reset        (reset),
        .st_in_data   (st_in_data),
        .st_in_valid  (st_in_valid),
        .st_in_ready  (st_in_ready),
        .st_out_data  (st_out_data),
        .st_out_valid (st_out_valid),
        .st_out_ready (st_out_ready)
`ifdef AVST_ADAPTER_PKT_EN
        ,
        .st_in_startofpacket  (in_sop),
        .st_in_endofpacket    (in_eop),
        .st_out_startofpacket (st_out_startofpacket),
        .st_out_endofpacket   (st_out_endofpacket)
`endif
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [IN_W-1:0] rand_word();
        logic [IN_W-1:0] w;
        for (int k = 0; k < IN_W / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic push_word(input logic [IN_W-1:0] w, input logic sop, input logic eop);
        exp_t e;
        e.data = w[255:128];
        e.sop  = sop;
        e.eop  = 1'b0;
        exp_q.push_back(e);
        e.data = w[127:0];
        e.sop  = 1'b0;
        e.eop  = eop;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted output beat is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (st_out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (st_out_valid && st_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none", st_out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 256'(st_out_data), 256'(mon_e.data));
`ifdef AVST_ADAPTER_PKT_EN
                check("out_sop", 256'(st_out_startofpacket), 256'(mon_e.sop));
                check("out_eop", 256'(st_out_endofpacket), 256'(mon_e.eop));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [IN_W-1:0] w, input logic sop, input logic eop, output int waits);
        bit got;
        waits = 0;
        got = 0;
        st_in_data  = w;
        st_in_valid = 1'b1;
        in_sop = sop;
        in_eop = eop;
        while (!got && waits < 100) begin
            @(negedge clock);
            if (st_in_ready) begin
                got = 1;
            end else begin
                @(posedge clock);
                #1;
                waits++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_ready required=ready");
            st_in_valid = 1'b0;
        end else begin
            push_word(w, sop, eop);
            @(posedge clock);
            #1;
            st_in_valid = 1'b0;
            in_sop = 1'b0;
            in_eop = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drained"}, 256'(exp_q.size()), 256'(0));
        @(negedge clock);
        check({name, "_idle_valid"}, 256'(st_out_valid), 256'(0));
        @(posedge clock);
        #1;
    endtask

    logic [IN_W-1:0] stream_w [4];
    logic [IN_W-1:0] rw;
    int              waits;
    int              acc;
    int              cyc;
    bit              took;

    initial begin
        stream_w[0] = {{16{8'h10}}, {16{8'h01}}};
        stream_w[1] = {{16{8'h20}}, {16{8'h02}}};
        stream_w[2] = {{16{8'h30}}, {16{8'h03}}};
        stream_w[3] = {{16{8'h40}}, {16{8'h04}}};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_out_valid", 256'(st_out_valid), 256'(0));
        check("reset_out_data", 256'(st_out_data), 256'(0));
        check("reset_in_ready", 256'(st_in_ready), 256'(1));
        @(posedge clock);
        #1;

        // Single word
        send_word({{16{8'hAA}}, {16{8'h55}}}, 1'b0, 1'b0, waits);
        drain("single");

        // Streaming: back-to-back words, no output gap
        max_run = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(stream_w[i], 1'b0, 1'b0, waits);
            if (i > 0) check("stream_ready_spacing", 256'(waits), 256'(1));
        end
        drain("stream");
        check("stream_gapless_run", 256'(max_run), 256'(8));

        // Backpressure on the second slice
        send_word({128'hDEADBEEF_CAFEF00D_01020304_05060708,
                   128'h01234567_89ABCDEF_FEDCBA98_76543210}, 1'b0, 1'b0, waits);
        @(posedge clock);
        #1;
        st_out_ready = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check("bp_valid", 256'(st_out_valid), 256'(1));
            check("bp_data", 256'(st_out_data), 256'(128'h01234567_89ABCDEF_FEDCBA98_76543210));
            check("bp_in_ready", 256'(st_in_ready), 256'(0));
        end
        @(posedge clock);
        #1;
        st_out_ready = 1'b1;
        drain("backpressure");

        // Reset after the first slice has gone
        send_word({{16{8'hC3}}, {16{8'h3C}}}, 1'b0, 1'b0, waits);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 256'(st_out_valid), 256'(0));
        check("async_reset_data", 256'(st_out_data), 256'(0));
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("post_reset_valid", 256'(st_out_valid), 256'(0));
        end
        @(posedge clock);
        #1;
        send_word({{16{8'h96}}, {16{8'h69}}}, 1'b0, 1'b0, waits);
        drain("post_reset");

`ifdef AVST_ADAPTER_PKT_EN
        // Three-word packet
        send_word({{16{8'hA0}}, {16{8'h0A}}}, 1'b1, 1'b0, waits);
        send_word({{16{8'hB0}}, {16{8'h0B}}}, 1'b0, 1'b0, waits);
        send_word({{16{8'hC0}}, {16{8'h0C}}}, 1'b0, 1'b1, waits);
        drain("packet");
`endif

        // Random valid/ready toggling
        acc = 0;
        cyc = 0;
        took = 0;
        st_in_valid = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            if (took) begin
                st_in_valid = 1'b0;
                took = 0;
            end
            if (!st_in_valid && $urandom_range(0, 1) == 1) begin
                rw = rand_word();
                st_in_data  = rw;
                st_in_valid = 1'b1;
            end
            st_out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clock);
            if (st_in_valid && st_in_ready) begin
                push_word(rw, 1'b0, 1'b0);
                acc++;
                took = 1;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        st_in_valid  = 1'b0;
        st_out_ready = 1'b1;
        check("random_words_accepted", 256'(acc), 256'(1000));
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
